// File: rtl/axi_pkg.sv
// AXI response codes shared by AXI / AXI-Lite blocks in this codebase.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_regs_wr_ctrl.sv
// Write-path control for the AXI-Lite register slave.
// Holds one AW entry and one W entry independently, decides when a write
// fires and owns the B channel.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   aw_*                   AW channel (address slot fill side)
//   w_*                    W channel (data/strobe slot fill side)
//   b_*                    B channel
//   wr_err_i               decode result for the slotted address (1 = SLVERR)
//   fire_o                 one-cycle strobe: slotted write is committed now
//   wr_addr_o/data/strb    contents of the slots, valid while fire_o is high
module axi_lite_regs_wr_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic                   wr_err_i,
  output logic                   fire_o,
  output logic [AddrWidth-1:0]   wr_addr_o,
  output logic [DataWidth-1:0]   wr_data_o,
  output logic [DataWidth/8-1:0] wr_strb_o
);

  logic aw_full_q;
  logic w_full_q;

  // Readies depend only on slot occupancy, never on the incoming valids.
  assign aw_ready_o = !aw_full_q;
  assign w_ready_o  = !w_full_q;

  // Commit needs both halves and a free B slot (or one leaving this cycle).
  assign fire_o = aw_full_q && w_full_q && (!b_valid_o || b_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      wr_addr_o <= '0;
    end else if (aw_valid_i && !aw_full_q) begin
      aw_full_q <= 1'b1;
      wr_addr_o <= aw_addr_i;
    end else if (fire_o) begin
      aw_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_full_q  <= 1'b0;
      wr_data_o <= '0;
      wr_strb_o <= '0;
    end else if (w_valid_i && !w_full_q) begin
      w_full_q  <= 1'b1;
      wr_data_o <= w_data_i;
      wr_strb_o <= w_strb_i;
    end else if (fire_o) begin
      w_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_o <= 1'b0;
      b_resp_o  <= RESP_OKAY;
    end else if (fire_o) begin
      b_valid_o <= 1'b1;
      b_resp_o  <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
    end else if (b_ready_i) begin
      b_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_regs_slv.sv
// AXI4-Lite register-bank slave.
// NumRegs registers of DataWidth bits, byte-strobe writes, per-register
// write protection, SLVERR on out-of-range or protected accesses.
//
// Handshake rule on every channel: a beat transfers on a rising clk_i edge
// where valid and ready are both high; a source holding valid keeps its
// payload stable until that edge, and no ready here depends on a valid.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   aw_*, w_*, b_*     AXI-Lite write channels
//   ar_*, r_*          AXI-Lite read channels
//   reg_q_o            all registers, register i at slice i
//   reg_wr_o           one-cycle pulse per register that was written
module axi_lite_regs_slv
  import axi_pkg::*;
#(
  parameter int unsigned                   AddrWidth    = 32,
  parameter int unsigned                   DataWidth    = 32,
  parameter int unsigned                   NumRegs      = 16,
  parameter logic [NumRegs-1:0]            ReadOnlyMask = '0,
  parameter logic [NumRegs*DataWidth-1:0]  RegRstVal    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [AddrWidth-1:0]           aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DataWidth-1:0]           w_data_i,
  input  logic [DataWidth/8-1:0]         w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [AddrWidth-1:0]           ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DataWidth-1:0]           r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NumRegs*DataWidth-1:0]   reg_q_o,
  output logic [NumRegs-1:0]             reg_wr_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = $clog2(NumRegs);

  typedef logic [IdxW-1:0]      idx_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  // Power-of-two sizing makes "addr < NumRegs*DataWidth/8" equal to
  // "no bits set above the index field".
  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return (addr >> (OffW + IdxW)) == '0;
  endfunction

  function automatic idx_t addr_idx(input logic [AddrWidth-1:0] addr);
    return addr[OffW +: IdxW];
  endfunction

  data_t                regs_q [NumRegs];
  logic                 wr_fire;
  logic                 wr_err;
  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  data_t                wr_data;
  strb_t                wr_strb;
  idx_t                 wr_idx;

  axi_lite_regs_wr_ctrl #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) u_wr_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .aw_addr_i  (aw_addr_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .w_data_i   (w_data_i),
    .w_strb_i   (w_strb_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .b_resp_o   (b_resp_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .wr_err_i   (wr_err),
    .fire_o     (wr_fire),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_strb_o  (wr_strb)
  );

  assign wr_idx = addr_idx(wr_addr);
  assign wr_err = !in_range(wr_addr) || ReadOnlyMask[wr_idx];
  assign wr_en  = wr_fire && !wr_err;

  // Byte offset bits are deliberately ignored by decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ar_addr_i, wr_addr};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= RegRstVal[i*DataWidth +: DataWidth];
      end
    end else if (wr_en) begin
      for (int k = 0; k < StrbWidth; k++) begin
        if (wr_strb[k]) begin
          regs_q[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
      end
    end
  end

  // Pulse even for an all-zero strobe: the access itself is the event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      if (wr_en) begin
        reg_wr_o[wr_idx] <= 1'b1;
      end
    end
  end

  assign ar_ready_o = !r_valid_o || r_ready_i;

  // Reads sample regs_q before any same-cycle write lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_resp_o  <= RESP_OKAY;
    end else if (ar_valid_i && ar_ready_o) begin
      r_valid_o <= 1'b1;
      if (in_range(ar_addr_i)) begin
        r_data_o <= regs_q[addr_idx(ar_addr_i)];
        r_resp_o <= RESP_OKAY;
      end else begin
        r_data_o <= '0;
        r_resp_o <= RESP_SLVERR;
      end
    end else if (r_ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_reg_q
    assign reg_q_o[i*DataWidth +: DataWidth] = regs_q[i];
  end

endmodule

// File: tb/tb_axi_lite_regs_slv.sv
// Bench for axi_lite_regs_slv: 16 x 32-bit registers, register 3 protected.
module tb_axi_lite_regs_slv;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          NR = 16;
  localparam logic [15:0] RO_MASK = 16'h0008;
  localparam int          CW = 530;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [AW-1:0]    aw_addr;
  logic             aw_valid, aw_ready;
  logic [DW-1:0]    w_data;
  logic [3:0]       w_strb;
  logic             w_valid, w_ready;
  logic [1:0]       b_resp;
  logic             b_valid, b_ready;
  logic [AW-1:0]    ar_addr;
  logic             ar_valid, ar_ready;
  logic [DW-1:0]    r_data;
  logic [1:0]       r_resp;
  logic             r_valid, r_ready;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr;

  axi_lite_regs_slv #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .NumRegs      (NR),
    .ReadOnlyMask (RO_MASK),
    .RegRstVal    ('0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aw_addr_i  (aw_addr),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .b_resp_o   (b_resp),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .ar_addr_i  (ar_addr),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .reg_q_o    (reg_q),
    .reg_wr_o   (reg_wr)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0]   model [NR];
  logic [529:0]  exp_b_q[$];   // {resp, pulse mask, register image after write}
  logic [33:0]   exp_r_q[$];   // {resp, data}
  int            b_issued = 0;
  int            r_issued = 0;
  int            b_hs_cnt = 0;
  int            r_hs_cnt = 0;
  bit            hold_b = 0;
  bit            hold_r = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s: no handshake within bound", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output logic [15:0] pulse);
    int idx;
    idx = int'((addr / 4) % 16);
    if (addr >= 32'd64 || RO_MASK[idx]) begin
      resp  = 2'b10;
      pulse = 16'h0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
      end
      resp  = 2'b00;
      pulse = 16'h1 << idx;
    end
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    if (addr >= 32'd64) return {2'b10, 32'h0};
    return {2'b00, model[int'((addr / 4) % 16)]};
  endfunction

  // ---------------- driver tasks ----------------
  // Tasks are entered just after a rising edge and return just after one.
  task automatic send_aw(input logic [31:0] addr, input int delay);
    int n;
    repeat (delay) begin @(posedge clk); #1; end
    aw_addr = addr;
    aw_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!aw_ready && n < 200) begin @(negedge clk); n++; end
    if (!aw_ready) timeout_fail("aw");
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
    int n;
    repeat (delay) begin @(posedge clk); #1; end
    w_data = data;
    w_strb = strb;
    w_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!w_ready && n < 200) begin @(negedge clk); n++; end
    if (!w_ready) timeout_fail("w");
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int n;
    ar_addr = addr;
    ar_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ar_ready && n < 200) begin @(negedge clk); n++; end
    if (!ar_ready) timeout_fail("ar");
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (b_hs_cnt < b_issued && n < 500) begin @(posedge clk); n++; end
    #1;
    if (b_hs_cnt < b_issued) timeout_fail("b");
  endtask

  task automatic wait_r_done();
    int n = 0;
    while (r_hs_cnt < r_issued && n < 500) begin @(posedge clk); n++; end
    #1;
    if (r_hs_cnt < r_issued) timeout_fail("r");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input bit wait_b);
    logic [1:0]  resp;
    logic [15:0] pulse;
    model_write(addr, data, strb, resp, pulse);
    exp_b_q.push_back({resp, pulse, model_flat()});
    b_issued++;
    fork
      send_aw(addr, aw_delay);
      send_w(data, strb, w_delay);
    join
    if (wait_b) wait_b_done();
  endtask

  task automatic do_read(input logic [31:0] addr, input bit wait_r);
    exp_r_q.push_back(model_read(addr));
    r_issued++;
    send_ar(addr);
    if (wait_r) wait_r_done();
  endtask

  // ---------------- response-side readies ----------------
  initial begin
    b_ready = 1'b0;
    r_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      b_ready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      r_ready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic         prev_bv, prev_bhs, prev_rv, prev_rhs;
  logic [1:0]   prev_bresp, prev_rresp;
  logic [31:0]  prev_rdata;
  logic [529:0] eb;
  logic [33:0]  er;

  initial begin
    prev_bv = 0; prev_bhs = 0; prev_rv = 0; prev_rhs = 0;
    prev_bresp = 0; prev_rresp = 0; prev_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bv = 0; prev_bhs = 0; prev_rv = 0; prev_rhs = 0;
        continue;
      end
      // B side: a response is new if B was idle or just handed off last edge.
      if (b_valid && (!prev_bv || prev_bhs)) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected b: resp %0h with no write outstanding", b_resp);
        end else begin
          eb = exp_b_q.pop_front();
          check("b_resp", CW'(b_resp), CW'(eb[529:528]));
          check("reg_wr pulse", CW'(reg_wr), CW'(eb[527:512]));
          check("reg_q after write", CW'(reg_q), CW'(eb[511:0]));
        end
      end else begin
        check("reg_wr idle", CW'(reg_wr), CW'(0));
      end
      if (prev_bv && !prev_bhs)
        check("b held stable", CW'({b_valid, b_resp}), CW'({1'b1, prev_bresp}));
      // R side.
      if (r_valid && (!prev_rv || prev_rhs)) begin
        if (exp_r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected r: data %0h with no read outstanding", r_data);
        end else begin
          er = exp_r_q.pop_front();
          check("r_resp", CW'(r_resp), CW'(er[33:32]));
          check("r_data", CW'(r_data), CW'(er[31:0]));
        end
      end
      if (prev_rv && !prev_rhs)
        check("r held stable", CW'({r_valid, r_resp, r_data}), CW'({1'b1, prev_rresp, prev_rdata}));
      if (b_valid && b_ready) b_hs_cnt++;
      if (r_valid && r_ready) r_hs_cnt++;
      prev_bv = b_valid;  prev_bhs = b_valid && b_ready;  prev_bresp = b_resp;
      prev_rv = r_valid;  prev_rhs = r_valid && r_ready;  prev_rresp = r_resp;
      prev_rdata = r_data;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d, ra;
    int idx;
    rst_n = 1'b0;
    aw_valid = 0; aw_addr = 0;
    w_valid = 0; w_data = 0; w_strb = 0;
    ar_valid = 0; ar_addr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst aw_ready", CW'(aw_ready), CW'(1));
    check("rst w_ready", CW'(w_ready), CW'(1));
    check("rst ar_ready", CW'(ar_ready), CW'(1));
    check("rst b_valid", CW'(b_valid), CW'(0));
    check("rst r_valid", CW'(r_valid), CW'(0));
    check("rst b_resp", CW'(b_resp), CW'(0));
    check("rst r_data/resp", CW'({r_resp, r_data}), CW'(0));
    check("rst reg_q", CW'(reg_q), CW'(0));
    @(posedge clk); #1;

    // Read after reset; R must follow the AR edge directly.
    do_read(32'h04, 0);
    @(negedge clk);
    check("r latency", CW'(r_valid), CW'(1));
    @(posedge clk);
    wait_r_done();

    // AW and W together, partial strobe.
    do_write(32'h08, 32'hDEADBEEF, 4'b0101, 0, 0, 1);
    check("reg2 value", CW'(reg_q[95:64]), CW'(32'h00AD00EF));
    do_read(32'h08, 1);

    // W first, AW later, to the protected register.
    do_write(32'h0C, 32'h1, 4'hF, 3, 0, 1);
    check("reg3 untouched", CW'(reg_q[127:96]), CW'(0));

    // Out of range.
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 1);
    do_read(32'h40, 1);

    // B backpressure: first B parks, second write waits in the slots.
    hold_b = 1;
    do_write(32'h10, $urandom, 4'hF, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    do_write(32'h14, $urandom, 4'hF, 0, 0, 0);
    @(negedge clk);
    check("slots full aw_ready", CW'(aw_ready), CW'(0));
    check("slots full w_ready", CW'(w_ready), CW'(0));
    check("b parked", CW'(b_valid), CW'(1));
    @(posedge clk); #1;
    hold_b = 0;
    wait_b_done();

    // R backpressure.
    hold_r = 1;
    do_read(32'h10, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("r parked ar_ready", CW'(ar_ready), CW'(0));
    check("r parked r_valid", CW'(r_valid), CW'(1));
    @(posedge clk); #1;
    hold_r = 0;
    wait_r_done();

    // Randomized traffic, sometimes a read and write to different registers at once.
    for (int t = 0; t < 80; t++) begin
      a = 32'($urandom_range(0, 20) * 4 + $urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 1);
        1: do_read(a, 1);
        default: begin
          idx = int'((a / 4) % 16);
          ra = 32'(((idx + 1 + $urandom_range(0, 14)) % 16) * 4);
          fork
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 1);
            do_read(ra, 1);
          join
        end
      endcase
    end

    // Make sure at least one register holds a nonzero value before reset.
    do_write(32'h18, 32'hA5A5A5A5, 4'hF, 0, 0, 1);

    // Reset while AW is slotted and W has not arrived.
    send_aw(32'h10, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-rst reg_q", CW'(reg_q), CW'(0));
    check("post-rst b_valid", CW'(b_valid), CW'(0));
    check("post-rst aw_ready", CW'(aw_ready), CW'(1));
    @(posedge clk); #1;
    // A lone W must wait for a fresh AW; a stale slot would write reg4 early.
    do_write(32'h14, 32'hCAFEF00D, 4'hF, 5, 0, 1);
    do_read(32'h10, 1);

    // Drain.
    begin
      int n = 0;
      while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 200) begin
        @(posedge clk); n++;
      end
    end
    check("b queue drained", CW'(exp_b_q.size()), CW'(0));
    check("r queue drained", CW'(exp_r_q.size()), CW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
